// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared opcodes, sequencer states and the pump phase pattern helper.
package pad_ctrl_pkg;
  localparam int MAX_PHASES = 32;
  typedef enum logic [1:0] {OP_NOP, OP_SET, OP_PUMP, OP_FLUSH} op_e;
  typedef enum logic [2:0] {S_IDLE, S_SET, S_STEP, S_FLUSH, S_FIN} state_e;
  // Closed-valve image for step s: only valve s is open; bits at or above phases stay closed.
  function automatic logic [MAX_PHASES-1:0] phase_pattern(input int s, input int phases);
    for (int i = 0; i < MAX_PHASES; i++) phase_pattern[i] = !(i == s && s < phases);
  endfunction
endpackage

// File: rtl/pump_phase_gen.sv
// pump_phase_gen: phase index and valve image for one peristaltic pump.
module pump_phase_gen import pad_ctrl_pkg::*; #(
  parameter int PHASES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              dir,
  input  logic              enable,
  output logic [PHASES-1:0] valves
);
  localparam int IW = $clog2(PHASES);
  localparam logic [IW-1:0] LAST = IW'(PHASES - 1);
  logic [IW-1:0] idx;
  logic rev;
  // clear latches the direction and seeds the first step of the stroke
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      rev <= 1'b0;
    end else if (clear) begin
      idx <= dir ? LAST : '0;
      rev <= dir;
    end else if (step) begin
      idx <= rev ? (idx == '0 ? LAST : idx - 1'b1) : (idx == LAST ? '0 : idx + 1'b1);
    end
  end
  assign valves = enable ? PHASES'(phase_pattern(32'(idx), PHASES)) : '1;
endmodule

// File: rtl/pad_ctrl_sequencer.sv
// pad_ctrl_sequencer: command-driven sequencer for control, pump and flush pad nets.
module pad_ctrl_sequencer import pad_ctrl_pkg::*; #(
  parameter int CTRL_WIDTH = 13,
  parameter int NUM_PUMPS  = 2,
  parameter int PHASES     = 3,
  parameter int FLUSH_SIZE = 22,
  parameter int COUNT_W    = 16,
  parameter int DWELL_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [NUM_PUMPS-1:0]        cmd_pump_mask,
  input  logic                        cmd_dir,
  input  logic [COUNT_W-1:0]          cmd_count,
  input  logic [DWELL_W-1:0]          cmd_dwell,
  input  logic [CTRL_WIDTH-1:0]       cmd_data,
  input  logic                        abort,
  output logic [CTRL_WIDTH-1:0]       ctrl_valves,
  output logic [NUM_PUMPS*PHASES-1:0] pump_valves,
  output logic [FLUSH_SIZE-1:0]       flush,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);
  localparam int IW = $clog2(PHASES);
  state_e state;
  logic [NUM_PUMPS-1:0] mask_r;
  logic [COUNT_W-1:0] strokes;
  logic [DWELL_W-1:0] dwl, rl;
  logic [CTRL_WIDTH-1:0] data_r;
  logic [IW-1:0] sc;
  logic run, accept, step;
  assign cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign step = state == S_STEP && run && !abort && dwl == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ctrl_valves <= '0;
      flush <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      run <= 1'b0;
      mask_r <= '0;
      strokes <= '0;
      dwl <= '0;
      rl <= '0;
      data_r <= '0;
      sc <= '0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          mask_r <= cmd_pump_mask;
          strokes <= cmd_count;
          data_r <= cmd_data;
          sc <= '0;
          dwl <= cmd_dwell == '0 ? '0 : cmd_dwell - 1'b1;
          rl <= cmd_dwell == '0 ? '0 : cmd_dwell - 1'b1;
          // an empty pump command still passes through STEP so done keeps its two-cycle latency
          run <= cmd_op == OP_PUMP && cmd_count != '0 && |cmd_pump_mask;
          flush <= cmd_op == OP_FLUSH ? FLUSH_SIZE'(1) : '0;
          state <= cmd_op == OP_SET ? S_SET : cmd_op == OP_PUMP ? S_STEP :
                   cmd_op == OP_FLUSH ? S_FLUSH : S_IDLE;
        end
        S_SET: begin
          if (!abort) ctrl_valves <= data_r;
          aborted <= abort;
          done <= 1'b1;
          state <= S_FIN;
        end
        S_STEP: if (abort || !run) begin
          run <= 1'b0;
          aborted <= abort;
          done <= 1'b1;
          state <= S_FIN;
        end else if (dwl != '0) begin
          dwl <= dwl - 1'b1;
        end else begin
          dwl <= rl;
          sc <= sc == IW'(PHASES - 1) ? '0 : sc + 1'b1;
          if (sc == IW'(PHASES - 1)) begin
            strokes <= strokes - 1'b1;
            if (strokes == COUNT_W'(1)) begin
              run <= 1'b0;
              done <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_FLUSH: if (abort || (dwl == '0 && flush[FLUSH_SIZE-1])) begin
          flush <= '0;
          aborted <= abort;
          done <= 1'b1;
          state <= S_FIN;
        end else if (dwl != '0) begin
          dwl <= dwl - 1'b1;
        end else begin
          dwl <= rl;
          flush <= flush << 1;
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  for (genvar p = 0; p < NUM_PUMPS; p++) begin : g_pump
    pump_phase_gen #(.PHASES(PHASES)) u_gen (
      .clk(clk),
      .rst(rst),
      .clear(accept),
      .step(step),
      .dir(cmd_dir),
      .enable(run && mask_r[p]),
      .valves(pump_valves[p*PHASES +: PHASES])
    );
  end
endmodule

// File: tb/tb_pad_ctrl_sequencer.sv
// tb_pad_ctrl_sequencer: table-driven command vectors plus hand-written timing traces.
module tb_pad_ctrl_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_pump_mask = '0;
  logic cmd_dir = 1'b0;
  logic [15:0] cmd_count = '0;
  logic [15:0] cmd_dwell = '0;
  logic [12:0] cmd_data = '0;
  logic abort = 1'b0;
  logic [12:0] ctrl_valves;
  logic [5:0] pump_valves;
  logic [21:0] flush;
  logic busy, done, aborted;
  int n_vec = 0;
  int n_err = 0;

  pad_ctrl_sequencer #(
    .CTRL_WIDTH(13), .NUM_PUMPS(2), .PHASES(3), .FLUSH_SIZE(22), .COUNT_W(16), .DWELL_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pump_mask(cmd_pump_mask), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .cmd_dwell(cmd_dwell), .cmd_data(cmd_data), .abort(abort), .ctrl_valves(ctrl_valves),
    .pump_valves(pump_valves), .flush(flush), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  mask;
    logic        dir;
    logic [15:0] count;
    logic [15:0] dwell;
    logic [12:0] data;
    int          ab_at;
    int          cyc;
    logic [12:0] ctrl;
    logic        ab;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] mask, input logic dir,
                       input logic [15:0] count, input logic [15:0] dwell, input logic [12:0] data);
    @(posedge clk);
    #1;
    cmd_op = op;
    cmd_pump_mask = mask;
    cmd_dir = dir;
    cmd_count = count;
    cmd_dwell = dwell;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] one3;
    logic [2:0] p3;
    logic [21:0] one22;
    int cyc;
    int seen;
    one3 = 3'b001;
    one22 = 22'd1;
    vecs[0]  = '{2'd1, 2'b00, 1'b0, 16'd0,   16'd0, 13'h1A5, 0, 2,  13'h1A5, 1'b0};
    vecs[1]  = '{2'd2, 2'b01, 1'b0, 16'd2,   16'd3, 13'h000, 0, 19, 13'h1A5, 1'b0};
    vecs[2]  = '{2'd2, 2'b11, 1'b1, 16'd1,   16'd0, 13'h000, 0, 4,  13'h1A5, 1'b0};
    vecs[3]  = '{2'd3, 2'b00, 1'b0, 16'd0,   16'd2, 13'h000, 0, 45, 13'h1A5, 1'b0};
    vecs[4]  = '{2'd2, 2'b11, 1'b0, 16'd0,   16'd4, 13'h000, 0, 2,  13'h1A5, 1'b0};
    vecs[5]  = '{2'd2, 2'b00, 1'b0, 16'd5,   16'd1, 13'h000, 0, 2,  13'h1A5, 1'b0};
    vecs[6]  = '{2'd3, 2'b00, 1'b0, 16'd0,   16'd1, 13'h000, 0, 23, 13'h1A5, 1'b0};
    vecs[7]  = '{2'd2, 2'b11, 1'b0, 16'd100, 16'd1, 13'h000, 7, 8,  13'h1A5, 1'b1};
    vecs[8]  = '{2'd2, 2'b01, 1'b0, 16'd1,   16'd1, 13'h000, 4, 4,  13'h1A5, 1'b0};
    vecs[9]  = '{2'd3, 2'b00, 1'b0, 16'd0,   16'd4, 13'h000, 5, 6,  13'h1A5, 1'b1};
    vecs[10] = '{2'd1, 2'b00, 1'b0, 16'd0,   16'd0, 13'h0F0, 1, 2,  13'h1A5, 1'b1};
    vecs[11] = '{2'd1, 2'b00, 1'b0, 16'd0,   16'd0, 13'h1FFF, 0, 2, 13'h1FFF, 1'b0};
    vecs[12] = '{2'd2, 2'b10, 1'b1, 16'd3,   16'd2, 13'h000, 0, 19, 13'h1FFF, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", ctrl_valves, 13'h0);
    chk("rst_pump", pump_valves, 6'h3F);
    chk("rst_flush", flush, 22'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    for (int v = 0; v < 13; v++) begin
      issue(vecs[v].op, vecs[v].mask, vecs[v].dir, vecs[v].count, vecs[v].dwell, vecs[v].data);
      cyc = 0;
      do begin
        cyc++;
        abort = (cyc == vecs[v].ab_at);
        @(negedge clk);
        if (done) break;
        @(posedge clk);
        #1;
      end while (cyc < 300);
      chk($sformatf("v%0d_done_cycle", v), cyc, vecs[v].cyc);
      chk($sformatf("v%0d_ctrl", v), ctrl_valves, vecs[v].ctrl);
      chk($sformatf("v%0d_aborted", v), aborted, vecs[v].ab);
      chk($sformatf("v%0d_pump_idle", v), pump_valves, 6'h3F);
      chk($sformatf("v%0d_flush_idle", v), flush, 22'h0);
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", v), cmd_ready, 1'b1);
      chk($sformatf("v%0d_done_once", v), done, 1'b0);
    end

    issue(2'd2, 2'b01, 1'b0, 16'd2, 16'd3, 13'h0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      p3 = ~(one3 << (((c - 1) / 3) % 3));
      chk($sformatf("fwd_trace_c%0d", c), pump_valves, {3'b111, p3});
    end
    @(negedge clk);
    chk("fwd_trace_done", done, 1'b1);

    issue(2'd2, 2'b11, 1'b1, 16'd1, 16'd0, 13'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      p3 = ~(one3 << (3 - c));
      chk($sformatf("rev_trace_c%0d", c), pump_valves, {p3, p3});
    end
    @(negedge clk);
    chk("rev_trace_closed", pump_valves, 6'h3F);

    issue(2'd3, 2'b00, 1'b0, 16'd0, 16'd2, 13'h0);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      chk($sformatf("flush_trace_c%0d", c), flush, one22 << ((c - 1) / 2));
    end
    @(negedge clk);
    chk("flush_trace_done", done, 1'b1);
    chk("flush_trace_clear", flush, 22'h0);

    @(posedge clk);
    #1;
    cmd_op = 2'd1;
    cmd_data = 13'h055;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_ready_c1", cmd_ready, 1'b0);
    @(negedge clk);
    chk("hold_ready_c2", cmd_ready, 1'b0);
    chk("hold_done_c2", done, 1'b1);
    @(negedge clk);
    chk("hold_ready_c3", cmd_ready, 1'b1);
    chk("hold_done_c3", done, 1'b0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_reaccept", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_ctrl", ctrl_valves, 13'h055);

    issue(2'd0, 2'b11, 1'b0, 16'd4, 16'd1, 13'h1FFF);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(busy) + int'(done);
    end
    chk("nop_ignored", seen, 0);
    chk("nop_ctrl", ctrl_valves, 13'h055);

    issue(2'd3, 2'b00, 1'b0, 16'd0, 16'd3, 13'h0);
    repeat (5) @(negedge clk);
    chk("midflush_active", flush, 22'h2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midflush_flush", flush, 22'h0);
    chk("midflush_busy", busy, 1'b0);
    chk("midflush_ctrl", ctrl_valves, 13'h0);
    seen = 0;
    repeat (5) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("midflush_no_done", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
